// File: rtl/bt_pkg.sv
// Shared definitions for the RN52 control interface: command ROM, string
// table, FSM states and default timing.
package bt_pkg;

  localparam int         CLKS_PER_BIT_DEF = 434;  // 115200 baud at 50 MHz
  localparam int         WAIT_BITS_DEF    = 17;   // 2**17 clk power-up / reboot wait
  localparam logic [7:0] CR               = 8'h0D;
  localparam int         ROM_AW           = 5;

  typedef enum logic [2:0] {
    PWR_WAIT,
    INIT0,
    INIT1,
    BOOT_WAIT,
    READY,
    SEND
  } state_e;

  typedef enum logic [1:0] {
    CMD_EQ     = 2'd0,  // "S-,HP_EQ\r"
    CMD_REBOOT = 2'd1,  // "R,1\r"
    CMD_NEXT   = 2'd2,  // "AT+\r"
    CMD_PREV   = 2'd3   // "AT-\r"
  } cmd_e;

  // First ROM address of each command string.
  function automatic logic [ROM_AW-1:0] cmd_addr(input logic [1:0] sel);
    case (sel)
      CMD_EQ:     return 5'd0;
      CMD_REBOOT: return 5'd9;
      CMD_NEXT:   return 5'd13;
      default:    return 5'd17;
    endcase
  endfunction

  // Length in bytes of each command string, terminating CR included.
  function automatic logic [3:0] cmd_len(input logic [1:0] sel);
    case (sel)
      CMD_EQ:  return 4'd9;
      default: return 4'd4;
    endcase
  endfunction

  // All four strings packed back to back.
  function automatic logic [7:0] cmd_rom(input logic [ROM_AW-1:0] addr);
    case (addr)
      5'd0:    return "S";
      5'd1:    return "-";
      5'd2:    return ",";
      5'd3:    return "H";
      5'd4:    return "P";
      5'd5:    return "_";
      5'd6:    return "E";
      5'd7:    return "Q";
      5'd8:    return CR;
      5'd9:    return "R";
      5'd10:   return ",";
      5'd11:   return "1";
      5'd12:   return CR;
      5'd13:   return "A";
      5'd14:   return "T";
      5'd15:   return "+";
      5'd16:   return CR;
      5'd17:   return "A";
      5'd18:   return "T";
      5'd19:   return "-";
      default: return CR;
    endcase
  endfunction

endpackage

// File: rtl/snd_cmd.sv
// Streams one command string from the ROM out of an 8N1 UART transmitter.
// Bytes of a string are sent back to back; done pulses for one clk after the
// stop bit of the final byte has completed.
module snd_cmd
  import bt_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] cmd_sel,
  output logic       TX,
  output logic       done
);

  localparam int            BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  logic              r_busy;
  logic              r_done;
  logic [BW-1:0]     r_baud;
  logic [3:0]        r_bit;
  logic [ROM_AW-1:0] r_addr;
  logic [3:0]        r_left;   // bytes still to send after the current one
  logic [9:0]        r_shift;  // {stop, data[7:0], start}; bit 0 is on the line

  assign TX   = r_shift[0];
  assign done = r_done;

  // Frame sequencing: load a byte, shift one bit per baud period, chain to the next byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_baud  <= '0;
      r_bit   <= '0;
      r_addr  <= '0;
      r_left  <= '0;
      r_shift <= '1;
    end else begin
      // NOTE: non-blocking assignments here so every register sees the pre-edge
      // values of the others, whatever order the statements are written in.
      r_done <= 1'b0;
      if (!r_busy) begin
        if (start) begin
          r_busy  <= 1'b1;
          r_baud  <= '0;
          r_bit   <= '0;
          r_addr  <= cmd_addr(cmd_sel) + 5'd1;
          r_left  <= cmd_len(cmd_sel) - 4'd1;
          r_shift <= {1'b1, cmd_rom(cmd_addr(cmd_sel)), 1'b0};
        end
      end else if (r_baud == BAUD_LAST) begin
        r_baud <= '0;
        if (r_bit == 4'd9) begin
          // Stop bit finished: either chain the next byte or end the string.
          r_bit <= '0;
          if (r_left == 4'd0) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_shift <= '1;
          end else begin
            r_addr  <= r_addr + 5'd1;
            r_left  <= r_left - 4'd1;
            r_shift <= {1'b1, cmd_rom(r_addr), 1'b0};
          end
        end else begin
          r_bit   <= r_bit + 4'd1;
          r_shift <= {1'b1, r_shift[9:1]};
        end
      end else begin
        r_baud <= r_baud + BW'(1);
      end
    end
  end

endmodule

// File: rtl/bt_intf.sv
// RN52 control interface: powers the module up in command mode, sends the
// init strings, then turns next/prev button releases into AT+ / AT- commands.
module bt_intf
  import bt_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int WAIT_BITS    = WAIT_BITS_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic next_n,
  input  logic prev_n,
  output logic cmd_n,
  output logic TX,
  input  logic RX
);

  logic [2:0]           r_next_sync;
  logic [2:0]           r_prev_sync;
  logic [1:0]           r_rx_sync;
  logic                 r_next_pend;
  logic                 r_prev_pend;
  logic [WAIT_BITS-1:0] r_wait;
  logic                 r_cmd_n;
  logic                 r_start;
  state_e               r_state;
  cmd_e                 r_sel;

  state_e w_state_nxt;
  cmd_e   w_sel;
  logic   w_start;
  logic   w_wait_inc;
  logic   w_wait_clr;
  logic   w_cmd_n_fall;
  logic   w_next_clr;
  logic   w_prev_clr;
  logic   w_done;
  logic   w_next_rel;
  logic   w_prev_rel;
  logic   w_wait_full;
  logic   w_rx_unused;

  // A release is the synchronized level going from pressed (0) to idle (1).
  assign w_next_rel  = ~r_next_sync[2] & r_next_sync[1];
  assign w_prev_rel  = ~r_prev_sync[2] & r_prev_sync[1];
  assign w_wait_full = &r_wait;
  assign w_rx_unused = r_rx_sync[1];  // RN52 replies are synchronized but not parsed yet
  assign cmd_n       = r_cmd_n;

  // Bring the asynchronous buttons and RX into the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_next_sync <= 3'b111;
      r_prev_sync <= 3'b111;
      r_rx_sync   <= 2'b11;
    end else begin
      r_next_sync <= {r_next_sync[1:0], next_n};
      r_prev_sync <= {r_prev_sync[1:0], prev_n};
      r_rx_sync   <= {r_rx_sync[0], RX};
    end
  end

  // Pending flags, wait counter, command-mode pin and the registered send request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_next_pend <= 1'b0;
      r_prev_pend <= 1'b0;
      r_wait      <= '0;
      r_cmd_n     <= 1'b1;
      r_start     <= 1'b0;
      r_sel       <= CMD_EQ;
    end else begin
      // A release in the same cycle as service is a new press and stays pending.
      if (w_next_rel)      r_next_pend <= 1'b1;
      else if (w_next_clr) r_next_pend <= 1'b0;
      if (w_prev_rel)      r_prev_pend <= 1'b1;
      else if (w_prev_clr) r_prev_pend <= 1'b0;

      if (w_wait_clr)      r_wait <= '0;
      else if (w_wait_inc) r_wait <= r_wait + WAIT_BITS'(1);

      if (w_cmd_n_fall) r_cmd_n <= 1'b0;

      r_start <= w_start;
      r_sel   <= w_sel;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= PWR_WAIT;
    else        r_state <= w_state_nxt;
  end

  // FSM next state and control strobes.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    w_state_nxt  = r_state;
    w_sel        = r_sel;
    w_start      = 1'b0;
    w_wait_inc   = 1'b0;
    w_wait_clr   = 1'b0;
    w_cmd_n_fall = 1'b0;
    w_next_clr   = 1'b0;
    w_prev_clr   = 1'b0;
    case (r_state)
      PWR_WAIT: begin
        w_wait_inc = 1'b1;
        if (w_wait_full) begin
          w_cmd_n_fall = 1'b1;
          w_start      = 1'b1;
          w_sel        = CMD_EQ;
          w_state_nxt  = INIT0;
        end
      end
      INIT0: begin
        if (w_done) begin
          w_start     = 1'b1;
          w_sel       = CMD_REBOOT;
          w_state_nxt = INIT1;
        end
      end
      INIT1: begin
        if (w_done) begin
          w_wait_clr  = 1'b1;
          w_state_nxt = BOOT_WAIT;
        end
      end
      BOOT_WAIT: begin
        w_wait_inc = 1'b1;
        if (w_wait_full) w_state_nxt = READY;
      end
      READY: begin
        if (r_next_pend) begin
          w_next_clr  = 1'b1;
          w_start     = 1'b1;
          w_sel       = CMD_NEXT;
          w_state_nxt = SEND;
        end else if (r_prev_pend) begin
          w_prev_clr  = 1'b1;
          w_start     = 1'b1;
          w_sel       = CMD_PREV;
          w_state_nxt = SEND;
        end
      end
      SEND: begin
        if (w_done) w_state_nxt = READY;
      end
      default: w_state_nxt = PWR_WAIT;
    endcase
  end

  snd_cmd #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_snd_cmd (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (r_start),
    .cmd_sel(r_sel),
    .TX     (TX),
    .done   (w_done)
  );

endmodule

// File: tb/tb_bt_intf.sv
// Directed bench for bt_intf: power-up timing, init strings, button commands,
// hold behaviour, pending/priority handling and mid-operation reset.
// Runs with shortened timing parameters; the UART decoder samples mid-bit.
module tb_bt_intf;

  localparam int CPB  = 8;
  localparam int WB   = 6;
  localparam int WAIT = 1 << WB;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic next_n = 1'b1;
  logic prev_n = 1'b1;
  logic RX     = 1'b1;
  logic cmd_n;
  logic TX;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  // Free-running cycle count used for latency measurements.
  always @(posedge clk) cyc <= cyc + 1;

  bt_intf #(
    .CLKS_PER_BIT(CPB),
    .WAIT_BITS   (WB)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .next_n(next_n),
    .prev_n(prev_n),
    .cmd_n (cmd_n),
    .TX    (TX),
    .RX    (RX)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Releases reset and checks cmd_n/TX on every clk up to the first start bit.
  task automatic power_up(input string tag);
    logic exp_cmd;
    logic exp_tx;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= WAIT + 1; k++) begin
      tick(1);
      exp_cmd = (k >= WAIT) ? 1'b0 : 1'b1;
      exp_tx  = (k == WAIT + 1) ? 1'b0 : 1'b1;
      checks++;
      if (cmd_n !== exp_cmd || TX !== exp_tx) begin
        errors++;
        $display("FAIL %s clk=%0d: cmd_n=%b TX=%b, expected cmd_n=%b TX=%b",
                 tag, k, cmd_n, TX, exp_cmd, exp_tx);
      end
    end
  endtask

  // Decodes one string from TX, checking data, framing and back-to-back bytes.
  task automatic rx_string(input string name, input string s, input int budget,
                           output int t_start, output int t_end);
    int         waited;
    logic [7:0] b;
    logic [7:0] e;
    logic       exp_line;
    waited  = 0;
    t_start = -1;
    t_end   = -1;
    while (TX !== 1'b0 && waited < budget) begin
      tick(1);
      waited++;
    end
    checks++;
    if (TX !== 1'b0) begin
      errors++;
      $display("FAIL %s: no start bit within %0d clks", name, budget);
      return;
    end
    t_start = cyc;
    for (int i = 0; i < s.len(); i++) begin
      tick(CPB / 2);
      checks++;
      if (TX !== 1'b0) begin
        errors++;
        $display("FAIL %s byte %0d start bit: TX=%b, expected 0", name, i, TX);
      end
      b = '0;
      for (int j = 0; j < 8; j++) begin
        tick(CPB);
        b[j] = TX;
      end
      e = s[i];
      checks++;
      if (b !== e) begin
        errors++;
        $display("FAIL %s byte %0d: got 0x%02h, expected 0x%02h", name, i, b, e);
      end
      tick(CPB);
      checks++;
      if (TX !== 1'b1) begin
        errors++;
        $display("FAIL %s byte %0d stop bit: TX=%b, expected 1", name, i, TX);
      end
      // Exactly 10 bit times after the start edge: next start bit or idle.
      tick(CPB - CPB / 2);
      exp_line = (i == s.len() - 1) ? 1'b1 : 1'b0;
      checks++;
      if (TX !== exp_line) begin
        errors++;
        $display("FAIL %s byte %0d frame end: TX=%b, expected %b", name, i, TX, exp_line);
      end
    end
    t_end = cyc;
  endtask

  task automatic check_idle(input string name, input int n);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick(1);
      if (TX !== 1'b1) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL %s: TX left idle during %0d clks, expected constant 1", name, n);
    end
  endtask

  task automatic press(input logic is_next, input int low_clks);
    @(negedge clk);
    if (is_next) next_n = 1'b0;
    else         prev_n = 1'b0;
    repeat (low_clks) @(negedge clk);
    next_n = 1'b1;
    prev_n = 1'b1;
  endtask

  task automatic check_latency(input string name, input int rel, input int t_start);
    checks++;
    if (t_start < rel + 1 || t_start > rel + 5) begin
      errors++;
      $display("FAIL %s latency: start bit %0d clks after release, expected 1..5",
               name, t_start - rel);
    end
  endtask

  task automatic test_reset();
    tick(3);
    checks++;
    if (cmd_n !== 1'b1) begin
      errors++;
      $display("FAIL reset cmd_n: got %b, expected 1", cmd_n);
    end
    checks++;
    if (TX !== 1'b1) begin
      errors++;
      $display("FAIL reset TX: got %b, expected 1", TX);
    end
    power_up("power_up");
  endtask

  task automatic test_init();
    int ts, te;
    rx_string("init0", "S-,HP_EQ\r", 4, ts, te);
    rx_string("init1", "R,1\r", 10, ts, te);
    checks++;
    if (cmd_n !== 1'b0) begin
      errors++;
      $display("FAIL init cmd_n: got %b, expected 0", cmd_n);
    end
    check_idle("boot_wait", WAIT + 20);
  endtask

  task automatic test_next();
    int rel, ts, te;
    press(1'b1, 2);
    rel = cyc;
    rx_string("next", "AT+\r", 20, ts, te);
    check_latency("next", rel, ts);
    check_idle("next_once", 30 * CPB);
  endtask

  task automatic test_prev();
    int rel, ts, te;
    tick(100);
    press(1'b0, 2);
    rel = cyc;
    rx_string("prev", "AT-\r", 20, ts, te);
    check_latency("prev", rel, ts);
    check_idle("prev_once", 30 * CPB);
  endtask

  task automatic test_hold();
    int rel, ts, te;
    @(negedge clk);
    next_n = 1'b0;
    check_idle("hold", 150);
    @(negedge clk);
    next_n = 1'b1;
    rel = cyc;
    rx_string("hold_release", "AT+\r", 20, ts, te);
    check_latency("hold_release", rel, ts);
    check_idle("hold_once", 30 * CPB);
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    rst_n = 1'b0;
    power_up("restart");
    tick(20);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (TX !== 1'b1 || cmd_n !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset immediate: TX=%b cmd_n=%b, expected 1 1", TX, cmd_n);
    end
    tick(1);
    checks++;
    if (TX !== 1'b1 || cmd_n !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset held: TX=%b cmd_n=%b, expected 1 1", TX, cmd_n);
    end
  endtask

  // Presses during INIT0 (prev first, next three times) must be served after
  // BOOT_WAIT as one AT+ followed by one AT-.
  task automatic test_pending_init();
    fork
      begin
        int ts, te, ts2, te2;
        power_up("reinit");
        rx_string("reinit0", "S-,HP_EQ\r", 4, ts, te);
        rx_string("reinit1", "R,1\r", 10, ts, te);
        rx_string("pend_next", "AT+\r", WAIT + 20, ts2, te2);
        checks++;
        if (ts2 < te + WAIT || ts2 > te + WAIT + 8) begin
          errors++;
          $display("FAIL pend_next after boot: start %0d clks after init end, expected %0d..%0d",
                   ts2 - te, WAIT, WAIT + 8);
        end
        rx_string("pend_prev", "AT-\r", 20, ts, te);
      end
      begin
        repeat (WAIT + 100) @(negedge clk);
        press(1'b0, 2);
        for (int i = 0; i < 3; i++) begin
          repeat (3) @(negedge clk);
          press(1'b1, 2);
        end
      end
    join
    check_idle("pend_once", 40 * CPB);
  endtask

  initial begin
    test_reset();
    test_init();
    test_next();
    test_prev();
    test_hold();
    test_mid_reset();
    test_pending_init();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
